// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone register-access initiator.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] WB_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC;

endpackage

// File: rtl/wb_initiator_if.sv
// Client request/response and Wishbone bus signals of the initiator.
interface wb_initiator_if #(
    parameter int APERWIDTH     = 17,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_we_i;
    logic [APERWIDTH-1:0]     req_adr_i;
    logic [3:0]               req_byte_stb_i;
    logic [31:0]              req_dat_i;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [31:0]              rsp_dat_o;
    logic                     rsp_err_o;
    logic [APERWIDTH-1:0]     WBm_ADR_o;
    logic                     WBm_CYC_o;
    logic                     WBm_STB_o;
    logic                     WBm_WE_o;
    logic                     WBm_RD_o;
    logic [3:0]               WBm_BYTE_STB_o;
    logic [31:0]              WBm_DAT_o;
    logic [31:0]              WBm_DAT_i;
    logic                     WBm_ACK_i;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_o;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_byte_stb_i,
        input  req_dat_i, rsp_ready_i, WBm_DAT_i, WBm_ACK_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o,
        output WBm_BYTE_STB_o, WBm_DAT_o, err_cnt_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_byte_stb_i,
        output req_dat_i, rsp_ready_i, WBm_DAT_i, WBm_ACK_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o,
        input  WBm_BYTE_STB_o, WBm_DAT_o, err_cnt_o
    );

endinterface

// File: rtl/wb_initiator_timeout.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
module wb_initiator_timeout #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == TERMINAL);

endmodule

// File: rtl/wb_initiator.sv
// Single-word Wishbone classic initiator with ACK timeout and error count.
module wb_initiator
    import wb_initiator_pkg::state_t,
           wb_initiator_pkg::IDLE,
           wb_initiator_pkg::BUS,
           wb_initiator_pkg::RESP,
           wb_initiator_pkg::WB_ADDR_ALIGN_MASK;
#(
    parameter int          APERWIDTH          = 17,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter logic [31:0] DEFAULT_READ_VALUE = wb_initiator_pkg::DEFAULT_READ_VALUE,
    parameter int          ERR_CNT_WIDTH      = 8
) (
    input  logic           WBs_CLK_i,
    input  logic           WBs_RST_n_i,
    wb_initiator_if.master bus
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 w_req_ready;
    logic                 w_rsp_valid;
    logic                 w_accept;
    logic                 w_leave;
    logic                 w_timeout;
    logic                 w_to_tc;
    logic                 w_ecnt_tc;
    logic [TW-1:0]        w_unused_to_cnt;
    logic [APERWIDTH-1:0] w_adr;

    logic [APERWIDTH-1:0] r_adr;
    logic                 r_stb;
    logic                 r_we;
    logic [3:0]           r_bstb;
    logic [31:0]          r_dat;
    logic [31:0]          r_rsp_dat;
    logic                 r_rsp_err;

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) r_state <= IDLE;
        else              r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid_i) w_next = BUS;
            end
            BUS: begin
                if (bus.WBm_ACK_i || w_to_tc) w_next = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept  = w_req_ready & bus.req_valid_i;
    assign w_leave   = (r_state == BUS) & (bus.WBm_ACK_i | w_to_tc);
    // ACK on the terminal cycle wins over the timeout
    assign w_timeout = (r_state == BUS) & ~bus.WBm_ACK_i & w_to_tc;
    assign w_adr     = bus.req_adr_i & WB_ADDR_ALIGN_MASK[APERWIDTH-1:0];

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            r_adr     <= '0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_bstb    <= 4'h0;
            r_dat     <= 32'h0;
            r_rsp_dat <= 32'h0;
            r_rsp_err <= 1'b0;
        end else if (w_accept) begin
            r_adr  <= w_adr;
            r_stb  <= 1'b1;
            r_we   <= bus.req_we_i;
            r_bstb <= bus.req_we_i ? bus.req_byte_stb_i : 4'hF;
            r_dat  <= bus.req_we_i ? bus.req_dat_i : 32'h0;
        end else if (w_leave) begin
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_bstb    <= 4'h0;
            r_dat     <= 32'h0;
            r_rsp_err <= ~bus.WBm_ACK_i;
            if (r_we)                r_rsp_dat <= 32'h0;
            else if (bus.WBm_ACK_i)  r_rsp_dat <= bus.WBm_DAT_i;
            else                     r_rsp_dat <= DEFAULT_READ_VALUE;
        end
    end

    wb_initiator_timeout #(
        .WIDTH    (TW),
        .TERMINAL (TO_TERM)
    ) u_timeout (
        .i_clk   (WBs_CLK_i),
        .i_rst_n (WBs_RST_n_i),
        .i_clr   (w_accept),
        .i_en    (r_state == BUS),
        .o_cnt   (w_unused_to_cnt),
        .o_tc    (w_to_tc)
    );

    wb_initiator_timeout #(
        .WIDTH    (ERR_CNT_WIDTH),
        .TERMINAL ('1)
    ) u_err_cnt (
        .i_clk   (WBs_CLK_i),
        .i_rst_n (WBs_RST_n_i),
        .i_clr   (1'b0),
        .i_en    (w_timeout & ~w_ecnt_tc),
        .o_cnt   (bus.err_cnt_o),
        .o_tc    (w_ecnt_tc)
    );

    assign bus.req_ready_o    = w_req_ready;
    assign bus.rsp_valid_o    = w_rsp_valid;
    assign bus.rsp_dat_o      = r_rsp_dat;
    assign bus.rsp_err_o      = r_rsp_err;
    assign bus.WBm_ADR_o      = r_adr;
    assign bus.WBm_CYC_o      = r_stb;
    assign bus.WBm_STB_o      = r_stb;
    assign bus.WBm_WE_o       = r_we;
    assign bus.WBm_RD_o       = r_stb & ~r_we;
    assign bus.WBm_BYTE_STB_o = r_bstb;
    assign bus.WBm_DAT_o      = r_dat;

endmodule
